irq_entry_ctrl: RTL and testbench

Downstream consumer of the NVIC `interrupt_active` vector. It arbitrates among active interrupts using the IPR priority fields and decides whether the winner preempts the running context. It raises an entry request to the core with a req/ack handshake, pulses the cleared pending bit back toward the NVIC, and tracks nested handler priority on a small stack popped by exception return.

---
 rtl/nvic_pkg.sv | 21 ++
 rtl/irq_prio_arbiter.sv | 32 +++
 rtl/irq_entry_ctrl.sv | 109 ++++++++++
 tb/tb_irq_entry_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nvic_pkg.sv
// nvic_pkg: shared defaults, FSM state and nesting-stack entry type for the
// interrupt entry path.
//   DEF_*        default parameter values for the entry controller
//   PRIO_THREAD  running priority when no handler is active (2**PRIO_W)
//   state_t      entry FSM states
//   stk_entry_t  one nesting-stack slot {irq index, priority}
package nvic_pkg;
    localparam int DEF_NUM_IRQ   = 8;
    localparam int DEF_PRIO_W    = 4;
    localparam int DEF_VECT_BASE = 16;
    localparam int DEF_MAX_NEST  = 4;
    localparam int DEF_IRQ_W     = $clog2(DEF_NUM_IRQ);
    localparam logic [DEF_PRIO_W:0] PRIO_THREAD = {1'b1, {DEF_PRIO_W{1'b0}}};

    typedef enum logic {ARB, REQ} state_t;

    typedef struct packed {
        logic [DEF_IRQ_W-1:0]  irq;
        logic [DEF_PRIO_W-1:0] prio;
    } stk_entry_t;
endpackage

// File: rtl/irq_prio_arbiter.sv
// irq_prio_arbiter: combinational pick of the active IRQ with the lowest
// priority value, lowest index on ties.
//   interrupt_active  enabled-and-pending vector
//   ipr               packed priority fields, IRQ n at [n*PRIO_W +: PRIO_W]
//   winner_valid      any IRQ active
//   winner_idx        winning IRQ index
//   winner_prio       winning IRQ priority
module irq_prio_arbiter #(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = 4,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_IRQ-1:0]        interrupt_active,
    input  logic [NUM_IRQ*PRIO_W-1:0] ipr,
    output logic                      winner_valid,
    output logic [IDX_W-1:0]          winner_idx,
    output logic [PRIO_W-1:0]         winner_prio
);
    // Scanning upward with a strict compare keeps the lower index on ties.
    always_comb begin
        winner_valid = 1'b0;
        winner_idx   = '0;
        winner_prio  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (interrupt_active[i] && (!winner_valid || ipr[i*PRIO_W +: PRIO_W] < winner_prio)) begin
                winner_valid = 1'b1;
                winner_idx   = IDX_W'(i);
                winner_prio  = ipr[i*PRIO_W +: PRIO_W];
            end
        end
    end
endmodule

// File: rtl/irq_entry_ctrl.sv
// irq_entry_ctrl: arbitrates active IRQs, requests handler entry from the core,
// clears the pending bit on acceptance and tracks nested handler priority.
//   clk, rst          clock; asynchronous active-low reset
//   interrupt_active  enabled-and-pending vector from the NVIC
//   IPR               packed priority fields, lower value = higher priority
//   primask           blocks new entries
//   core_ack          core accepts the pending request
//   exc_return        core leaves the current handler
//   core_req          entry request to the core
//   core_exc_num      exception number of the request (VECT_BASE + irq)
//   clr_pend          one-hot pulse clearing the accepted IRQ's pending bit
//   cur_prio          running priority, 2**PRIO_W in thread mode
//   nest_depth        handlers on the stack
//   nest_err          pulse on exc_return with an empty stack
module irq_entry_ctrl
    import nvic_pkg::*;
#(
    parameter int NUM_IRQ   = DEF_NUM_IRQ,
    parameter int PRIO_W    = DEF_PRIO_W,
    parameter int VECT_BASE = DEF_VECT_BASE,
    parameter int MAX_NEST  = DEF_MAX_NEST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IRQ-1:0]            interrupt_active,
    input  logic [NUM_IRQ*PRIO_W-1:0]     IPR,
    input  logic                          primask,
    input  logic                          core_ack,
    input  logic                          exc_return,
    output logic                          core_req,
    output logic [7:0]                    core_exc_num,
    output logic [NUM_IRQ-1:0]            clr_pend,
    output logic [PRIO_W:0]               cur_prio,
    output logic [$clog2(MAX_NEST+1)-1:0] nest_depth,
    output logic                          nest_err
);
    localparam int IRQ_W   = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
    localparam int DEPTH_W = $clog2(MAX_NEST+1);
    localparam int SLOT_W  = MAX_NEST > 1 ? $clog2(MAX_NEST) : 1;
    localparam logic [PRIO_W:0] THREAD = {1'b1, {PRIO_W{1'b0}}};

    state_t             state;
    logic [IRQ_W-1:0]   lat_irq;
    logic [PRIO_W-1:0]  lat_prio;
    stk_entry_t         stack [MAX_NEST];
    logic               win_valid;
    logic [IRQ_W-1:0]   win_idx;
    logic [PRIO_W-1:0]  win_prio;
    logic               pop_ok;
    logic [DEPTH_W-1:0] depth_pop;
    logic [PRIO_W:0]    prio_pop;
    logic               ack;
    logic               withdraw;
    logic               preempt;

    irq_prio_arbiter #(.NUM_IRQ(NUM_IRQ), .PRIO_W(PRIO_W), .IDX_W(IRQ_W)) u_arb (
        .interrupt_active(interrupt_active),
        .ipr(IPR),
        .winner_valid(win_valid),
        .winner_idx(win_idx),
        .winner_prio(win_prio)
    );

    // Return is applied before a same-cycle push, so the push lands in the
    // slot freed by the pop and depth is unchanged.
    assign pop_ok    = exc_return && nest_depth != '0;
    assign depth_pop = nest_depth - DEPTH_W'(pop_ok);
    assign prio_pop  = depth_pop == '0 ? THREAD : {1'b0, stack[SLOT_W'(depth_pop - DEPTH_W'(1))].prio};
    assign ack       = state == REQ && core_ack;
    assign withdraw  = state == REQ && (!interrupt_active[lat_irq] || primask);
    assign preempt   = win_valid && {1'b0, win_prio} < cur_prio && !primask && nest_depth < DEPTH_W'(MAX_NEST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB;
            core_req     <= 1'b0;
            core_exc_num <= '0;
            clr_pend     <= '0;
            cur_prio     <= THREAD;
            nest_depth   <= '0;
            nest_err     <= 1'b0;
            lat_irq      <= '0;
            lat_prio     <= '0;
            for (int i = 0; i < MAX_NEST; i++) stack[i] <= '0;
        end else begin
            clr_pend <= '0;
            nest_err <= exc_return && nest_depth == '0;
            if (ack) begin
                stack[SLOT_W'(depth_pop)] <= '{irq: lat_irq, prio: lat_prio};
                nest_depth                <= depth_pop + DEPTH_W'(1);
                cur_prio                  <= {1'b0, lat_prio};
                clr_pend                  <= NUM_IRQ'(1) << lat_irq;
            end else if (pop_ok) begin
                nest_depth <= depth_pop;
                cur_prio   <= prio_pop;
            end
            if (state == ARB && preempt) begin
                state        <= REQ;
                core_req     <= 1'b1;
                lat_irq      <= win_idx;
                lat_prio     <= win_prio;
                core_exc_num <= 8'(VECT_BASE) + 8'(win_idx);
            end else if (ack || withdraw) begin
                state    <= ARB;
                core_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_irq_entry_ctrl.sv
// tb_irq_entry_ctrl: directed scenarios plus randomized traffic checked against
// a queue-based reference model of interrupt entry and nesting.
module tb_irq_entry_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ia  = '0;
    logic [31:0] ipr = '0;
    logic        pm  = 1'b0;
    logic        ack = 1'b0;
    logic        er  = 1'b0;
    logic        core_req;
    logic [7:0]  core_exc_num;
    logic [7:0]  clr_pend;
    logic [4:0]  cur_prio;
    logic [2:0]  nest_depth;
    logic        nest_err;

    irq_entry_ctrl dut (
        .clk(clk),
        .rst(rst),
        .interrupt_active(ia),
        .IPR(ipr),
        .primask(pm),
        .core_ack(ack),
        .exc_return(er),
        .core_req(core_req),
        .core_exc_num(core_exc_num),
        .clr_pend(clr_pend),
        .cur_prio(cur_prio),
        .nest_depth(nest_depth),
        .nest_err(nest_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a pending request plus a stack of accepted handlers.
    bit m_req;
    int m_irq, m_prio, m_exc, m_clr, m_err;
    int stk_irq[$];
    int stk_prio[$];

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_cur();
        return stk_prio.size() != 0 ? stk_prio[$] : 16;
    endfunction

    function automatic int prio_of(input int i);
        return int'((ipr >> (4 * i)) & 32'hF);
    endfunction

    function automatic void model_reset();
        m_req = 0; m_irq = 0; m_prio = 0; m_exc = 0; m_clr = 0; m_err = 0;
        stk_irq.delete();
        stk_prio.delete();
    endfunction

    function automatic void model_step();
        int d0, cur0, best;
        bit req0;
        d0 = stk_prio.size();
        cur0 = m_cur();
        req0 = m_req;
        m_clr = 0;
        m_err = 0;
        if (er) begin
            if (d0 == 0) m_err = 1;
            else begin
                void'(stk_prio.pop_back());
                void'(stk_irq.pop_back());
            end
        end
        if (req0) begin
            if (ack) begin
                stk_prio.push_back(m_prio);
                stk_irq.push_back(m_irq);
                m_clr = 1 << m_irq;
                m_req = 0;
            end else if (!ia[m_irq] || pm) m_req = 0;
        end else begin
            best = 16;
            for (int i = 0; i < 8; i++) if (ia[i] && prio_of(i) < best) best = prio_of(i);
            if (best < cur0 && !pm && d0 < 4) begin
                for (int i = 0; i < 8; i++) begin
                    if (ia[i] && prio_of(i) == best) begin
                        m_irq = i; m_prio = best; m_exc = 16 + i; m_req = 1;
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic chk_all();
        check("core_req", core_req, int'(m_req));
        check("core_exc_num", core_exc_num, m_exc);
        check("clr_pend", clr_pend, m_clr);
        check("cur_prio", cur_prio, m_cur());
        check("nest_depth", nest_depth, stk_prio.size());
        check("nest_err", nest_err, m_err);
    endtask

    task automatic step(input logic [7:0] a, input bit p, input bit k, input bit r);
        ia = a; pm = p; ack = k; er = r;
        @(posedge clk);
        model_step();
        #1;
        chk_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        check("reset_cur_prio", cur_prio, 16);
        @(negedge clk);
        rst = 1'b1;

        // Tie and entry
        ipr = 32'h0000C008;
        step(8'h06, 0, 0, 0);
        check("t1_req", core_req, 1);
        check("t1_exc", core_exc_num, 17);
        step(8'h06, 0, 1, 0);
        check("t1_clr", clr_pend, 8'h02);
        check("t1_cur", cur_prio, 0);
        check("t1_depth", nest_depth, 1);

        // Equal priority does not preempt
        step(8'h04, 0, 0, 0);
        check("t2_noreq", core_req, 0);
        step(8'h04, 0, 0, 1);
        check("t2_cur", cur_prio, 16);
        step(8'h04, 0, 0, 0);
        check("t2_exc", core_exc_num, 18);
        step(8'h04, 0, 1, 0);
        step(8'h00, 0, 0, 1);

        // Nesting
        step(8'h08, 0, 0, 0);
        step(8'h08, 0, 1, 0);
        step(8'h09, 0, 0, 0);
        check("t3_exc", core_exc_num, 16);
        step(8'h09, 0, 1, 0);
        check("t3_depth", nest_depth, 2);
        step(8'h00, 0, 0, 1);
        check("t3_cur1", cur_prio, 12);
        step(8'h00, 0, 0, 1);
        check("t3_cur2", cur_prio, 16);

        // Withdraw
        step(8'h02, 0, 0, 0);
        step(8'h00, 0, 0, 0);
        check("t4_req", core_req, 0);
        check("t4_clr", clr_pend, 0);
        check("t4_depth", nest_depth, 0);

        // Masking and stack full
        step(8'h02, 1, 0, 0);
        check("t5_mask", core_req, 0);
        ipr = 32'h1357C008;
        for (int i = 4; i < 8; i++) begin
            step(8'(1 << i), 0, 0, 0);
            step(8'(1 << i), 0, 1, 0);
        end
        check("t5_full", nest_depth, 4);
        check("t5_cur", cur_prio, 1);
        step(8'h02, 0, 0, 0);
        step(8'h02, 0, 0, 0);
        check("t5_blocked", core_req, 0);
        step(8'h02, 0, 0, 1);
        step(8'h02, 0, 0, 0);
        check("t5_exc", core_exc_num, 17);
        step(8'h02, 0, 1, 0);
        repeat (4) step(8'h00, 0, 0, 1);

        // Errors and asynchronous reset
        step(8'h00, 0, 0, 1);
        check("t6_err", nest_err, 1);
        step(8'h00, 0, 0, 0);
        check("t6_err_clr", nest_err, 0);
        step(8'h02, 0, 0, 0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk_all();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] a;
            if (c % 200 == 0) ipr = $urandom;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : ia;
            step(a, $urandom_range(0, 15) == 0,
                 m_req ? $urandom_range(0, 2) == 0 : $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
